// File: rtl/multi_alarm_sched_pkg.sv
// Shared types and constants for the multi-alarm scheduler.
// Time is packed {H[16:12], M[11:6], S[5:0]}. The hms_t struct gives named slices of that packing.
package multi_alarm_sched_pkg;

    localparam int unsigned TIME_W        = 17;
    localparam int unsigned H_W           = 5;
    localparam int unsigned M_W           = 6;
    localparam int unsigned S_W           = 6;
    localparam int unsigned MIN_PER_HOUR  = 60;
    localparam int unsigned HOURS_PER_DAY = 24;

    // Field view of a packed time word: h = [16:12], m = [11:6], s = [5:0].
    typedef struct packed {
        logic [H_W-1:0] h;
        logic [M_W-1:0] m;
        logic [S_W-1:0] s;
    } hms_t;

    // Scheduler FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RING = 1'b1
    } state_e;

endpackage

// File: rtl/multi_alarm_sched_if.sv
// Bus between the time calculator / key controller and the alarm scheduler.
// The i_* signals are scheduler inputs and the o_* signals are scheduler outputs.
// The slave modport is the scheduler side. The master modport is the driving side.
interface multi_alarm_sched_if
    import multi_alarm_sched_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned IDX_W      = 2
);
    logic                  i_tick_1hz;
    logic [TIME_W-1:0]     i_cur_time;
    logic                  i_wr_en;
    logic [IDX_W-1:0]      i_wr_idx;
    logic [TIME_W-1:0]     i_wr_time;
    logic                  i_wr_alm_en;
    logic                  i_dismiss;
    logic                  i_snooze;
    logic                  o_ringing;
    logic [IDX_W-1:0]      o_ring_idx;
    logic [NUM_ALARMS-1:0] o_en_mask;
    logic [NUM_ALARMS-1:0] o_snooze_mask;
    logic                  o_missed;

    modport master (
        output i_tick_1hz, i_cur_time, i_wr_en, i_wr_idx, i_wr_time, i_wr_alm_en,
               i_dismiss, i_snooze,
        input  o_ringing, o_ring_idx, o_en_mask, o_snooze_mask, o_missed
    );

    modport slave (
        input  i_tick_1hz, i_cur_time, i_wr_en, i_wr_idx, i_wr_time, i_wr_alm_en,
               i_dismiss, i_snooze,
        output o_ringing, o_ring_idx, o_en_mask, o_snooze_mask, o_missed
    );
endinterface

// File: rtl/multi_alarm_sched_time_add_min.sv
// Combinational adder that adds a minute count to a packed time word.
// Seconds are unchanged. Minutes wrap at 60 and carry into the hour. The hour wraps 24 -> 0.
// The minute addend must be 0..59, so a single minute wrap is enough.
// Ports:
//   i_time    packed time word
//   i_min     minutes to add (0..59)
//   o_time_c  resulting packed time word
module time_add_min
    import multi_alarm_sched_pkg::*;
(
    input  logic [TIME_W-1:0] i_time,
    input  logic [M_W-1:0]    i_min,
    output logic [TIME_W-1:0] o_time_c
);
    hms_t           w_in;
    hms_t           w_out;
    logic [M_W:0]   w_min_sum;
    logic [H_W:0]   w_hr_sum;
    logic           w_carry;

    always_comb begin
        w_in      = hms_t'(i_time);
        w_out     = w_in;
        w_min_sum = {1'b0, w_in.m} + {1'b0, i_min};
        w_carry   = (w_min_sum >= (M_W+1)'(MIN_PER_HOUR));
        if (w_carry) begin
            w_min_sum = w_min_sum - (M_W+1)'(MIN_PER_HOUR);
        end
        w_hr_sum  = {1'b0, w_in.h} + (H_W+1)'(w_carry);
        if (w_hr_sum == (H_W+1)'(HOURS_PER_DAY)) begin
            w_hr_sum = '0;
        end
        w_out.m   = w_min_sum[M_W-1:0];
        w_out.h   = w_hr_sum[H_W-1:0];
        o_time_c  = w_out;
    end
endmodule

// File: rtl/multi_alarm_sched.sv
// Multi-channel alarm scheduler.
// On each 1 Hz tick it matches every channel's alarm time and snooze time against the current time.
// A match marks the channel pending. Pending channels ring one at a time, lowest index first.
// It also handles snooze with a per-ring limit, auto-timeout with a sticky MISSED flag, and config writes.
// Ports:
//   i_clk, i_rst   clock and asynchronous active-high reset
//   bus (slave)    time/tick, config write, keys in; ringing, ring index, masks, missed out
module multi_alarm_sched
    import multi_alarm_sched_pkg::*;
#(
    parameter int unsigned NUM_ALARMS     = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned MAX_SNOOZE     = 3,
    parameter int unsigned RING_TIMEOUT_S = 60
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    multi_alarm_sched_if.slave    bus
);
    localparam int unsigned CNT_W = (MAX_SNOOZE < 3)     ? 2 : $clog2(MAX_SNOOZE + 1);
    localparam int unsigned TMO_W = (RING_TIMEOUT_S < 2) ? 1 : $clog2(RING_TIMEOUT_S);

    // Per-channel state
    logic [TIME_W-1:0]     r_alm_time [NUM_ALARMS];
    logic [TIME_W-1:0]     r_snz_time [NUM_ALARMS];
    logic [CNT_W-1:0]      r_snz_cnt  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_en;
    logic [NUM_ALARMS-1:0] r_snz_pend;
    logic [NUM_ALARMS-1:0] r_pend;

    // Ring FSM
    state_e                r_state;
    logic [IDX_W-1:0]      r_ring_idx;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_missed;

    logic [NUM_ALARMS-1:0] w_main_hit;
    logic [NUM_ALARMS-1:0] w_snz_hit;
    logic [NUM_ALARMS-1:0] w_fire;
    logic [NUM_ALARMS-1:0] w_cand;
    logic [NUM_ALARMS-1:0] w_pend_nxt;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [TIME_W-1:0]     w_snz_sum;
    logic [CNT_W-1:0]      w_ring_cnt;
    logic                  w_ring;
    logic                  w_wr_ok;
    logic                  w_wr_kill_ring;
    logic                  w_key;
    logic                  w_do_snooze;
    logic                  w_timeout;

    // Lowest set bit of v. Returns 0 when v is empty, so callers qualify the result with |v.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_ALARMS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    time_add_min u_snz_add (
        .i_time   (bus.i_cur_time),
        .i_min    (M_W'(SNOOZE_MIN)),
        .o_time_c (w_snz_sum)
    );

    // Trigger matching, candidate selection and key/timeout decode
    always_comb begin
        w_main_hit = '0;
        w_snz_hit  = '0;
        w_fire     = '0;
        w_ring     = (r_state == ST_RING);
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_main_hit[i] = bus.i_tick_1hz && r_en[i] && (bus.i_cur_time == r_alm_time[i]);
            w_snz_hit[i]  = bus.i_tick_1hz && r_en[i] && r_snz_pend[i]
                            && (bus.i_cur_time == r_snz_time[i]);
            // The channel currently sounding must not queue itself again.
            w_fire[i]     = (w_main_hit[i] || w_snz_hit[i])
                            && !(w_ring && (r_ring_idx == IDX_W'(i)));
        end
        w_cand     = r_pend | w_fire;
        w_sel_idx  = lowest_idx(w_cand);
        w_pend_nxt = w_cand;
        if (!w_ring && (|w_cand)) begin
            w_pend_nxt = w_cand & ~(NUM_ALARMS'(1) << w_sel_idx);
        end
        w_ring_cnt     = r_snz_cnt[r_ring_idx];
        w_wr_ok        = bus.i_wr_en && (32'(bus.i_wr_idx) < NUM_ALARMS);
        w_wr_kill_ring = w_wr_ok && !bus.i_wr_alm_en && w_ring && (bus.i_wr_idx == r_ring_idx);
        w_key          = bus.i_dismiss || bus.i_snooze;
        w_do_snooze    = bus.i_snooze && !bus.i_dismiss && (w_ring_cnt < CNT_W'(MAX_SNOOZE));
        w_timeout      = bus.i_tick_1hz && (r_tmo_cnt == TMO_W'(RING_TIMEOUT_S - 1));
    end

    // State update. Later assignments win: triggers, then ring FSM, then config write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_alm_time[i] <= '0;
                r_snz_time[i] <= '0;
                r_snz_cnt[i]  <= '0;
            end
            r_en       <= '0;
            r_snz_pend <= '0;
            r_pend     <= '0;
            r_state    <= ST_IDLE;
            r_ring_idx <= '0;
            r_tmo_cnt  <= '0;
            r_missed   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (w_fire[i] && w_main_hit[i]) r_snz_cnt[i]  <= '0;
                if (w_fire[i] && w_snz_hit[i])  r_snz_pend[i] <= 1'b0;
            end
            r_pend <= w_pend_nxt;

            case (r_state)
                ST_IDLE: begin
                    if (|w_cand) begin
                        r_state    <= ST_RING;
                        r_ring_idx <= w_sel_idx;
                        r_tmo_cnt  <= '0;
                    end
                end
                ST_RING: begin
                    if (w_key) begin
                        r_missed <= 1'b0;
                        r_state  <= ST_IDLE;
                        if (w_do_snooze) begin
                            r_snz_time[r_ring_idx] <= w_snz_sum;
                            r_snz_pend[r_ring_idx] <= 1'b1;
                            r_snz_cnt[r_ring_idx]  <= w_ring_cnt + CNT_W'(1);
                        end else begin
                            r_snz_pend[r_ring_idx] <= 1'b0;
                            r_snz_cnt[r_ring_idx]  <= '0;
                        end
                    end else if (w_wr_kill_ring) begin
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_missed               <= 1'b1;
                        r_state                <= ST_IDLE;
                        r_snz_pend[r_ring_idx] <= 1'b0;
                        r_snz_cnt[r_ring_idx]  <= '0;
                    end else if (bus.i_tick_1hz) begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_wr_ok) begin
                r_alm_time[bus.i_wr_idx] <= bus.i_wr_time;
                r_en[bus.i_wr_idx]       <= bus.i_wr_alm_en;
                r_snz_pend[bus.i_wr_idx] <= 1'b0;
                r_snz_cnt[bus.i_wr_idx]  <= '0;
            end
        end
    end

    assign bus.o_ringing     = (r_state == ST_RING);
    assign bus.o_ring_idx    = r_ring_idx;
    assign bus.o_en_mask     = r_en;
    assign bus.o_snooze_mask = r_snz_pend;
    assign bus.o_missed      = r_missed;

endmodule

// File: tb/tb_multi_alarm_sched.sv
// Bench for multi_alarm_sched: directed scenarios followed by randomized traffic.
// The reference model keeps times as seconds-of-day and the ringing channel as an int (-1 = silent).
module tb_multi_alarm_sched;
    localparam int NA      = 4;
    localparam int IW      = 2;
    localparam int SNZ_MIN = 5;
    localparam int MAX_SNZ = 3;
    localparam int TMO_S   = 60;
    localparam int DAY     = 86400;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_alarm_sched_if #(.NUM_ALARMS(NA), .IDX_W(IW)) u_if ();

    multi_alarm_sched #(
        .NUM_ALARMS(NA), .IDX_W(IW), .SNOOZE_MIN(SNZ_MIN),
        .MAX_SNOOZE(MAX_SNZ), .RING_TIMEOUT_S(TMO_S)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_alm [NA];
    int m_snzt[NA];
    int m_cnt [NA];
    bit m_en  [NA];
    bit m_snzp[NA];
    bit m_pend[NA];
    int m_ring;
    int m_tmo;
    bit m_missed;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int to_secs(input logic [16:0] t);
        return int'(t[16:12]) * 3600 + int'(t[11:6]) * 60 + int'(t[5:0]);
    endfunction

    function automatic logic [16:0] to_packed(input int s);
        int h;
        int m;
        int sec;
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        return {5'(h), 6'(m), 6'(sec)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_alm[i] = 0; m_snzt[i] = 0; m_cnt[i] = 0;
            m_en[i] = 0; m_snzp[i] = 0; m_pend[i] = 0;
        end
        m_ring = -1; m_tmo = 0; m_missed = 0;
    endtask

    // Next model state from the inputs currently on the bus.
    task automatic model_step();
        int cur, r, pick, widx;
        bit tick, dis, snz, hit_a, hit_s;
        int n_cnt[NA];
        int n_snzt[NA];
        bit n_snzp[NA];
        bit n_pend[NA];
        int n_ring, n_tmo;
        bit n_missed;
        cur  = to_secs(u_if.i_cur_time);
        tick = u_if.i_tick_1hz;
        dis  = u_if.i_dismiss;
        snz  = u_if.i_snooze;
        widx = int'(u_if.i_wr_idx);
        n_cnt = m_cnt; n_snzt = m_snzt; n_snzp = m_snzp; n_pend = m_pend;
        n_ring = m_ring; n_tmo = m_tmo; n_missed = m_missed;

        for (int i = 0; i < NA; i++) begin
            if (tick && m_en[i] && m_ring != i) begin
                hit_a = (cur == m_alm[i]);
                hit_s = m_snzp[i] && (cur == m_snzt[i]);
                if (hit_a) n_cnt[i] = 0;
                if (hit_s) n_snzp[i] = 0;
                if (hit_a || hit_s) n_pend[i] = 1;
            end
        end

        if (m_ring < 0) begin
            pick = -1;
            for (int i = 0; i < NA; i++) if (n_pend[i] && pick < 0) pick = i;
            if (pick >= 0) begin
                n_ring = pick; n_tmo = 0; n_pend[pick] = 0;
            end
        end else begin
            r = m_ring;
            if (dis || snz) begin
                n_missed = 0; n_ring = -1;
                if (snz && !dis && m_cnt[r] < MAX_SNZ) begin
                    n_snzt[r] = (cur + SNZ_MIN * 60) % DAY;
                    n_snzp[r] = 1;
                    n_cnt[r]  = m_cnt[r] + 1;
                end else begin
                    n_snzp[r] = 0; n_cnt[r] = 0;
                end
            end else if (u_if.i_wr_en && widx < NA && !u_if.i_wr_alm_en && widx == r) begin
                n_ring = -1;
            end else if (tick) begin
                if (m_tmo == TMO_S - 1) begin
                    n_missed = 1; n_ring = -1; n_snzp[r] = 0; n_cnt[r] = 0;
                end else begin
                    n_tmo = m_tmo + 1;
                end
            end
        end

        if (u_if.i_wr_en && widx < NA) begin
            m_alm[widx] = to_secs(u_if.i_wr_time);
            m_en[widx]  = u_if.i_wr_alm_en;
            n_snzp[widx] = 0;
            n_cnt[widx]  = 0;
        end
        m_cnt = n_cnt; m_snzt = n_snzt; m_snzp = n_snzp; m_pend = n_pend;
        m_ring = n_ring; m_tmo = n_tmo; m_missed = n_missed;
    endtask

    task automatic compare_all();
        int em, sm;
        em = 0; sm = 0;
        for (int i = 0; i < NA; i++) begin
            if (m_en[i])   em |= (1 << i);
            if (m_snzp[i]) sm |= (1 << i);
        end
        check_eq("ringing", int'(u_if.o_ringing), (m_ring >= 0) ? 1 : 0);
        if (m_ring >= 0) check_eq("ring_idx", int'(u_if.o_ring_idx), m_ring);
        check_eq("en_mask", int'(u_if.o_en_mask), em);
        check_eq("snz_mask", int'(u_if.o_snooze_mask), sm);
        check_eq("missed", int'(u_if.o_missed), int'(m_missed));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        u_if.i_tick_1hz = 1'b0;
        u_if.i_dismiss  = 1'b0;
        u_if.i_snooze   = 1'b0;
        u_if.i_wr_en    = 1'b0;
    endtask

    task automatic tick_at(input int secs);
        u_if.i_cur_time = to_packed(secs % DAY);
        u_if.i_tick_1hz = 1'b1;
        step();
    endtask

    task automatic press(input bit dis, input bit snz);
        u_if.i_dismiss = dis;
        u_if.i_snooze  = snz;
        step();
    endtask

    task automatic write_alarm(input int idx, input int secs, input bit en);
        u_if.i_wr_en     = 1'b1;
        u_if.i_wr_idx    = IW'(idx);
        u_if.i_wr_time   = to_packed(secs % DAY);
        u_if.i_wr_alm_en = en;
        step();
    endtask

    initial begin
        int t, base, off;
        u_if.i_tick_1hz = 0; u_if.i_cur_time = '0; u_if.i_wr_en = 0;
        u_if.i_wr_idx = '0; u_if.i_wr_time = '0; u_if.i_wr_alm_en = 0;
        u_if.i_dismiss = 0; u_if.i_snooze = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        step();

        // Ring and dismiss at 07:30:00
        write_alarm(0, 7*3600 + 30*60, 1);
        tick_at(7*3600 + 29*60 + 59);
        check_eq("early_quiet", int'(u_if.o_ringing), 0);
        tick_at(7*3600 + 30*60);
        check_eq("ring0_on", int'(u_if.o_ringing), 1);
        check_eq("ring0_idx", int'(u_if.o_ring_idx), 0);
        press(1, 0);
        check_eq("ring0_off", int'(u_if.o_ringing), 0);

        // Snooze across midnight, then the 4th snooze acts as dismiss
        write_alarm(0, 23*3600 + 58*60, 1);
        tick_at(23*3600 + 58*60);
        for (int k = 1; k <= 10; k++) tick_at(23*3600 + 58*60 + k);
        t = 23*3600 + 58*60 + 10;
        for (int k = 1; k <= 4; k++) begin
            press(0, 1);
            check_eq("snz_quiet", int'(u_if.o_ringing), 0);
            check_eq("snz_mask0", int'(u_if.o_snooze_mask[0]), (k <= MAX_SNZ) ? 1 : 0);
            if (k <= MAX_SNZ) begin
                t = (t + SNZ_MIN * 60) % DAY;
                if (k == 1) check_eq("snz_wrap_secs", t, 190);
                tick_at(t - 1);
                tick_at(t);
                check_eq("snz_rering", int'(u_if.o_ringing), 1);
            end
        end
        write_alarm(0, 0, 0);

        // Simultaneous ch1 and ch3 at 06:00:00
        write_alarm(1, 6*3600, 1);
        write_alarm(3, 6*3600, 1);
        tick_at(6*3600);
        check_eq("sim_first", int'(u_if.o_ring_idx), 1);
        press(1, 0);
        check_eq("sim_gap", int'(u_if.o_ringing), 0);
        step();
        check_eq("sim_second_on", int'(u_if.o_ringing), 1);
        check_eq("sim_second", int'(u_if.o_ring_idx), 3);
        press(1, 0);

        // Timeout on ch2, MISSED sticky across an idle dismiss, cleared by snooze
        write_alarm(2, 8*3600, 1);
        tick_at(8*3600);
        for (int k = 1; k < TMO_S; k++) tick_at(8*3600 + k);
        check_eq("tmo_still", int'(u_if.o_ringing), 1);
        tick_at(8*3600 + TMO_S);
        check_eq("tmo_off", int'(u_if.o_ringing), 0);
        check_eq("tmo_missed", int'(u_if.o_missed), 1);
        press(1, 0);
        check_eq("idle_dis_missed", int'(u_if.o_missed), 1);
        tick_at(8*3600);
        press(0, 1);
        check_eq("snz_clr_missed", int'(u_if.o_missed), 0);
        write_alarm(2, 8*3600, 0);

        // Disable while ringing, then dismiss+snooze race
        write_alarm(0, 10*3600, 1);
        tick_at(10*3600);
        write_alarm(0, 10*3600, 0);
        check_eq("dis_off", int'(u_if.o_ringing), 0);
        check_eq("dis_snz", int'(u_if.o_snooze_mask), 0);
        write_alarm(0, 10*3600, 1);
        tick_at(10*3600);
        press(1, 1);
        check_eq("race_off", int'(u_if.o_ringing), 0);
        check_eq("race_snz", int'(u_if.o_snooze_mask), 0);

        // Asynchronous reset in the middle of a ring
        tick_at(6*3600);
        check_eq("pre_rst_ring", int'(u_if.o_ringing), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_ringing", int'(u_if.o_ringing), 0);
        check_eq("rst_en", int'(u_if.o_en_mask), 0);
        check_eq("rst_snz", int'(u_if.o_snooze_mask), 0);
        check_eq("rst_missed", int'(u_if.o_missed), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Randomized traffic in a 400 s window straddling midnight
        base = 23*3600 + 55*60;
        off  = 0;
        for (int i = 0; i < NA; i++) write_alarm(i, base + int'($urandom_range(400, 0)), 1);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(3, 0) != 0) begin
                off = (off >= 400) ? 0 : off + 1;
                u_if.i_cur_time = to_packed((base + off) % DAY);
                u_if.i_tick_1hz = 1'b1;
            end
            u_if.i_dismiss = ($urandom_range(63, 0) == 0);
            u_if.i_snooze  = ($urandom_range(47, 0) == 0);
            if ($urandom_range(31, 0) == 0) begin
                u_if.i_wr_en     = 1'b1;
                u_if.i_wr_idx    = IW'($urandom_range(NA - 1, 0));
                u_if.i_wr_time   = to_packed((base + int'($urandom_range(400, 0))) % DAY);
                u_if.i_wr_alm_en = ($urandom_range(3, 0) != 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
